// File: rtl/systolic_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_operand_feeder_if
// Description : Bundle between the operand feeder and its neighbours.
//               Carries the ready/valid load port (A rows / B columns), the
//               start/busy/done control, and the skewed operand stream
//               (A_in, B_in, valid_in) that drives the systolic array.
//               Element k of a vector occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
//               Operands are two's-complement and are carried bit-exact.
// Modports    : master - load/control source (drives ld_*, start)
//               slave  - the feeder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_operand_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                             ld_valid;
    logic                             ld_ready;
    logic                             ld_sel;
    logic [IDX_W-1:0]                 ld_idx;
    logic [N-1:0][DATA_WIDTH-1:0]     ld_data;
    logic                             start;
    logic                             busy;
    logic                             done;
    logic [N-1:0][DATA_WIDTH-1:0]     A_in;
    logic [N-1:0][DATA_WIDTH-1:0]     B_in;
    logic                             valid_in;

    modport master (
        output ld_valid, ld_sel, ld_idx, ld_data, start,
        input  ld_ready, busy, done, A_in, B_in, valid_in
    );

    modport slave (
        input  ld_valid, ld_sel, ld_idx, ld_data, start,
        output ld_ready, busy, done, A_in, B_in, valid_in
    );
endinterface
`default_nettype wire

// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_operand_feeder
// Description : Holds one NxN A matrix (by rows) and one NxN B matrix (by
//               columns). On start it streams 2N-1 diagonally skewed, zero
//               padded beats into a systolic array, waits DRAIN_CYCLES for
//               the array to settle, then pulses done for one cycle.
// Ports       : clk - rising-edge clock
//               rst - asynchronous reset, active low
//               bus - systolic_operand_feeder_if.slave (load port, start/
//                     busy/done, A_in/B_in/valid_in stream)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_operand_feeder #(
    parameter int DATA_WIDTH   = 16,
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    systolic_operand_feeder_if.slave   bus
);
    localparam int c_last_beat = 2*N - 2;
    localparam int c_t_w       = $clog2(2*N);
    localparam int c_drain_w   = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    state_t                 state_q, state_d;
    logic [c_t_w-1:0]       t_q, t_d;
    logic [c_drain_w-1:0]   drain_q, drain_d;
    // a_mem_q[i][k] = A[i][k]; b_mem_q[j][k] = B[k][j]
    vec_t                   a_mem_q [N];
    vec_t                   a_mem_d [N];
    vec_t                   b_mem_q [N];
    vec_t                   b_mem_d [N];
    vec_t                   a_in_q, a_in_d;
    vec_t                   b_in_q, b_in_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [c_t_w-1:0]       beat_idx;
    vec_t                   beat_a;
    vec_t                   beat_b;

    assign bus.ld_ready = (state_q == S_IDLE);
    assign bus.A_in     = a_in_q;
    assign bus.B_in     = b_in_q;
    assign bus.valid_in = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Storage writes only in IDLE. The beat launched at the same edge reads
    // a_mem_q/b_mem_q, so a load coincident with start affects beats >= 1.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_mem_d[r] = a_mem_q[r];
            b_mem_d[r] = b_mem_q[r];
        end
        if (state_q == S_IDLE && bus.ld_valid) begin
            if (!bus.ld_sel) begin
                a_mem_d[bus.ld_idx] = bus.ld_data;
            end else begin
                b_mem_d[bus.ld_idx] = bus.ld_data;
            end
        end
    end

    // Beat about to be registered: beat 0 when launching from IDLE,
    // otherwise the successor of the beat currently on the outputs.
    // Lane i carries element k of its row/column when i + k == beat.
    always_comb begin
        beat_idx = (state_q == S_IDLE) ? '0 : t_q + 1'b1;
        beat_a   = '0;
        beat_b   = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(beat_idx) == i + k) begin
                    beat_a[i] = a_mem_q[i][k];
                    beat_b[i] = b_mem_q[i][k];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        a_in_d  = '0;
        b_in_d  = '0;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                    a_in_d  = beat_a;
                    b_in_d  = beat_b;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                if (t_q == c_t_w'(c_last_beat)) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = c_drain_w'(DRAIN_CYCLES);
                    end
                end else begin
                    t_d     = t_q + 1'b1;
                    a_in_d  = beat_a;
                    b_in_d  = beat_b;
                    valid_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q <= c_drain_w'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            drain_q <= '0;
            for (int r = 0; r < N; r++) begin
                a_mem_q[r] <= '0;
                b_mem_q[r] <= '0;
            end
            a_in_q  <= '0;
            b_in_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            drain_q <= drain_d;
            for (int r = 0; r < N; r++) begin
                a_mem_q[r] <= a_mem_d[r];
                b_mem_q[r] <= b_mem_d[r];
            end
            a_in_q  <= a_in_d;
            b_in_q  <= b_in_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_operand_feeder
// Description : Self-checking bench for systolic_operand_feeder. A reference
//               model of the A/B storage produces the expected skewed beats,
//               which are queued at start and compared as valid_in beats
//               appear. Control timing (busy/done/valid_in) is checked per run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_operand_feeder;
    localparam int DW    = 16;
    localparam int N     = 4;
    localparam int DRAIN = 4;
    localparam int BEATS = 2*N - 1;
    localparam int LAT   = 2*N - 1 + DRAIN;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct packed { vec_t a; vec_t b; } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_operand_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    systolic_operand_feeder #(
        .DATA_WIDTH   (DW),
        .N            (N),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] ma [N][N];   // ma[i][k] = A[i][k]
    logic [DW-1:0] mb [N][N];   // mb[k][j] = B[k][j]
    beat_t sb [$];
    beat_t mon_exp;
    int    beat_no = 0;

    function automatic beat_t model_beat(input int t);
        beat_t r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r.a[i] = ma[i][t-i];
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r.b[j] = mb[t-j][j];
        return r;
    endfunction

    function automatic vec_t mkv(input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v[0] = DW'(e0); v[1] = DW'(e1); v[2] = DW'(e2); v[3] = DW'(e3);
        return v;
    endfunction

    // Beat monitor: every valid_in beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.valid_in) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat valid_in=1 with none expected: A_in=%h B_in=%h",
                         bus.A_in, bus.B_in);
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.A_in, bus.B_in} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL beat%0d actual A_in=%h B_in=%h required A_in=%h B_in=%h",
                             beat_no, bus.A_in, bus.B_in, mon_exp.a, mon_exp.b);
                end
            end
            beat_no++;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = '0;
                mb[i][k] = '0;
            end
    endtask

    task automatic load(input bit sel, input int idx, input vec_t data);
        @(negedge clk);
        vectors++;
        if (bus.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_ready_idle actual %b required 1", bus.ld_ready);
        end
        bus.ld_valid = 1'b1;
        bus.ld_sel   = sel;
        bus.ld_idx   = 2'(idx);
        bus.ld_data  = data;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!sel) ma[idx][k] = data[k];
            else      mb[k][idx] = data[k];
        end
    endtask

    // One full run, optionally with a load coincident with start, a start
    // poke at cycle poke_start and a (rejected) load at cycle poke_load.
    task automatic do_run(input string name, input bit with_load, input bit sel,
                          input int idx, input vec_t data,
                          input int poke_start, input int poke_load);
        beat_t b0;
        int busy_cnt = 0, valid_cnt = 0, done_cnt = 0, done_at = -1;
        @(negedge clk);
        b0 = model_beat(0);
        if (with_load) begin
            bus.ld_valid = 1'b1;
            bus.ld_sel   = sel;
            bus.ld_idx   = 2'(idx);
            bus.ld_data  = data;
            for (int k = 0; k < N; k++) begin
                if (!sel) ma[idx][k] = data[k];
                else      mb[k][idx] = data[k];
            end
        end
        bus.start = 1'b1;
        sb.push_back(b0);
        for (int t = 1; t < BEATS; t++) sb.push_back(model_beat(t));
        @(posedge clk); #1;
        for (int c = 0; c < LAT + 5; c++) begin
            if (bus.busy === 1'b1)     busy_cnt++;
            if (bus.valid_in === 1'b1) valid_cnt++;
            if (bus.done === 1'b1) begin done_cnt++; done_at = c; end
            bus.start = (c == poke_start);
            if (c == poke_load) begin
                bus.ld_valid = 1'b1;
                bus.ld_sel   = 1'b0;
                bus.ld_idx   = '0;
                bus.ld_data  = mkv(99, 99, 99, 99);
                vectors++;
                if (bus.ld_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s ld_ready_busy actual %b required 0", name, bus.ld_ready);
                end
            end else begin
                bus.ld_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        vectors++;
        if (done_at !== LAT) begin
            miscompares++;
            $display("FAIL %s done_latency actual %0d required %0d", name, done_at, LAT);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses actual %0d required 1", name, done_cnt);
        end
        vectors++;
        if (busy_cnt !== LAT) begin
            miscompares++;
            $display("FAIL %s busy_cycles actual %0d required %0d", name, busy_cnt, LAT);
        end
        vectors++;
        if (valid_cnt !== BEATS) begin
            miscompares++;
            $display("FAIL %s valid_cycles actual %0d required %0d", name, valid_cnt, BEATS);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL %s beats_missing actual %0d left required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string name, input logic exp_ready);
        vectors++;
        if (bus.A_in !== '0 || bus.B_in !== '0) begin
            miscompares++;
            $display("FAIL %s operands actual A_in=%h B_in=%h required 0", name, bus.A_in, bus.B_in);
        end
        vectors++;
        if ({bus.valid_in, bus.busy, bus.done} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s valid/busy/done actual %b%b%b required 000",
                     name, bus.valid_in, bus.busy, bus.done);
        end
        vectors++;
        if (bus.ld_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL %s ld_ready actual %b required %b", name, bus.ld_ready, exp_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released", 1'b1);
        clear_model();
        do_run("cleared_storage", 1'b0, 1'b0, 0, '0, -1, -1);
    endtask

    task automatic test_identity();
        load(1'b0, 0, mkv(1, 2, 3, 4));
        load(1'b0, 1, mkv(5, 6, 7, 8));
        load(1'b0, 2, mkv(9, 10, 11, 12));
        load(1'b0, 3, mkv(13, 14, 15, 16));
        for (int j = 0; j < N; j++)
            load(1'b1, j, mkv(j == 0, j == 1, j == 2, j == 3));
        do_run("identity", 1'b0, 1'b0, 0, '0, -1, -1);
    endtask

    task automatic test_load_while_busy();
        do_run("load_busy", 1'b0, 1'b0, 0, '0, -1, 2);
        do_run("rerun_original", 1'b0, 1'b0, 0, '0, -1, -1);
    endtask

    task automatic test_load_with_start();
        do_run("load_with_start", 1'b1, 1'b0, 0, mkv(7, 7, 7, 7), -1, -1);
    endtask

    task automatic test_signed_extremes();
        load(1'b0, 1, mkv(-32768, 32767, -1, 1));
        load(1'b1, 2, mkv(32767, -32768, 1, -1));
        do_run("signed_extremes_busy_start", 1'b0, 1'b0, 0, '0, 3, -1);
    endtask

    task automatic test_reset_mid_drain();
        int done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 0; t < BEATS; t++) sb.push_back(model_beat(t));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (BEATS + 1) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_drain_busy actual %b required 1", bus.busy);
        end
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_in_drain", 1'b1);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < LAT + 5; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_in_drain_done actual %0d pulses required 0", done_cnt);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_in_drain_beats actual %0d left required 0", sb.size());
        end
        sb.delete();
        do_run("post_reset_storage", 1'b0, 1'b0, 0, '0, -1, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_sel   = 1'b0;
        bus.ld_idx   = '0;
        bus.ld_data  = '0;
        bus.start    = 1'b0;
        clear_model();
        test_reset();
        test_identity();
        test_load_while_busy();
        test_load_with_start();
        test_signed_extremes();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
